register_file_bank: RTL and testbench
=====================================

Name: register_file_bank

Overview:
- MIPS 32-entry general-purpose register file for the pipeline's decode stage.
- Owns the architectural register storage, the write decoder and the two read ports.
- Each read port selects one stored word through a 32-to-1 read mux.
- Results feed the ID/EX pipeline register. The write port is driven from the WB stage.

Parameters:
- WORD_LENGTH, 32: bits per register.
- NBITS, 5: register address width (log2 of 32 entries).
- SP_INIT, 32'h7FFF_EFFC: reset value of register 29 ($sp).
- GP_INIT, 32'h1000_8000: reset value of register 28 ($gp).

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- Reg_Write  input  1  write enable from WB stage
- Write_Register  input  NBITS  destination register address
- Write_Data  input  WORD_LENGTH  data to write
- Read_Register_1  input  NBITS  read port 1 address (rs)
- Read_Register_2  input  NBITS  read port 2 address (rt)
- Read_Data_1  output  WORD_LENGTH  read port 1 data
- Read_Data_2  output  WORD_LENGTH  read port 2 data

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). Both are fixed.
- Storage: 32 registers of WORD_LENGTH bits, all updated only on the rising edge of clk.
- Reset: sampled at the rising edge while reset=1.
  - All registers go to 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - Reset has priority over any simultaneous write.
  - Reset asserted mid-operation discards the pending write that cycle.
- Read data outputs carry no reset of their own. From the cycle after reset they show the reset contents of the addressed registers: 0, GP_INIT or SP_INIT.
- Write: at a rising edge with reset=0, Reg_Write=1 and Write_Register!=0, register[Write_Register] <= Write_Data.
  - Writes to register 0 are discarded; register 0 stays 0 permanently.
  - Reg_Write=0 leaves all registers unchanged.
- Read: combinational from current storage, zero-cycle latency.
  - Read_Data_n = register[Read_Register_n].
  - A write becomes visible on the read ports after the rising edge that commits it.
- Register 0 always reads 0, including under bypass.
- Both ports may address the same register. Both then return the identical value.
- No state machine: the block is storage plus decode. The only sequential element is the register array.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding. When all of the following hold, Read_Data_n = Write_Data, combinationally in the same cycle:
  - Reg_Write=1
  - reset=0
  - Write_Register==Read_Register_n
  - Write_Register!=0
- This removes the WB-to-ID hazard window. Each port is evaluated independently.
- Not defined: no forwarding. A read of the register being written returns the old stored value until after the edge.

Decomposition:
- Shared package holds:
  - REG_ZERO=0, REG_GP=28, REG_SP=29
  - default SP_INIT/GP_INIT
  - NUM_REGS=32
- Natural sub-module: register_file_read_port, one instance per port.
  - Wraps the team's existing 32-to-1 mux.
  - Applies the optional bypass override and the register-0 force-to-zero.
- The write decoder and storage stay in the top module.

Test Plan:
- Reset: assert reset one cycle, then read regs 0, 28, 29, 5 -> 0, 32'h1000_8000, 32'h7FFF_EFFC, 0.
- Basic write/read: write reg 8 = 32'hDEAD_BEEF. Next cycle, Read_Register_1=8 -> Read_Data_1=32'hDEAD_BEEF. Read_Register_2=9 -> 0.
- Register 0 protection: write reg 0 = 32'hFFFF_FFFF. Reading reg 0 on both ports -> 0, both in the same cycle and afterwards.
- Same-cycle read of written register (reg 10 holds 32'h1, write 32'h2):
  - Without macro: 32'h1 that cycle, 32'h2 next.
  - With REGFILE_WRITE_BYPASS_EN: 32'h2 that cycle.
- Reset priority: reset=1 with Reg_Write=1, Write_Register=29, Write_Data=32'h1234 -> reg 29 reads SP_INIT after the edge, not 32'h1234.
- Exhaustive sweep: write reg i = i*32'h0101_0101 for i=1..31, then read all via both ports -> every value matches; reg 0 = 0.

Source files
------------

// File: rtl/register_file_bank_pkg.sv
// ---------------------------------------------------------------------------
// register_file_bank_pkg
// Shared constants for the MIPS general-purpose register file: the number of
// architectural registers, the register indices that have special reset
// behaviour, and the default reset values for $gp and $sp.
// ---------------------------------------------------------------------------
package register_file_bank_pkg;

  localparam int NUM_REGS = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage : register_file_bank_pkg

// File: rtl/register_file_bank_read_port.sv
// ---------------------------------------------------------------------------
// register_file_read_port
// One read port of the register file: a 32-to-1 mux over the stored words,
// an optional same-cycle write-to-read bypass, and a force-to-zero when
// register 0 is addressed (register 0 reads 0 even if a bypass would match).
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   defined   -> a committing write to the addressed register is forwarded
//                combinationally to o_data in the same cycle
//   undefined -> o_data always shows the stored value
//
// Ports:
//   i_regs_flat  all stored words, register k at [k*WORD_LENGTH +: WORD_LENGTH]
//   i_addr       register address to read
//   i_wr_fire    a write commits at the next edge (already excludes reset and
//                register 0)
//   i_wr_addr    address of that write
//   i_wr_data    data of that write
//   o_data       read data
// ---------------------------------------------------------------------------
module register_file_read_port
  import register_file_bank_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NBITS       = 5
) (
  input  logic [NUM_REGS*WORD_LENGTH-1:0] i_regs_flat,
  input  logic [NBITS-1:0]                i_addr,
  input  logic                            i_wr_fire,
  input  logic [NBITS-1:0]                i_wr_addr,
  input  logic [WORD_LENGTH-1:0]          i_wr_data,
  output logic [WORD_LENGTH-1:0]          o_data
);

  logic [WORD_LENGTH-1:0] w_words [NUM_REGS];
  logic [WORD_LENGTH-1:0] w_mux;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unflatten
    assign w_words[gi] = i_regs_flat[gi*WORD_LENGTH +: WORD_LENGTH];
  end

  assign w_mux = w_words[i_addr];

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    o_data = w_mux;
    if (i_wr_fire && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
    // Register 0 wins over everything, including a matching bypass.
    if (i_addr == NBITS'(REG_ZERO)) begin
      o_data = '0;
    end
  end
`else
  // Write-side inputs only matter when forwarding is built in.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_fire, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = w_mux;
    if (i_addr == NBITS'(REG_ZERO)) begin
      o_data = '0;
    end
  end
`endif

endmodule : register_file_read_port

// File: rtl/register_file_bank.sv
// ---------------------------------------------------------------------------
// register_file_bank
// MIPS 32-entry general-purpose register file for the decode stage. Holds the
// architectural storage and the write decoder, and feeds two combinational
// read ports (rs, rt) toward the ID/EX pipeline register.
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read
// forwarding, implemented inside register_file_read_port).
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset; beats any write
//   Reg_Write        write enable from WB
//   Write_Register   destination register (writes to register 0 are dropped)
//   Write_Data       data to write
//   Read_Register_1  rs address      Read_Data_1  rs data
//   Read_Register_2  rt address      Read_Data_2  rt data
// ---------------------------------------------------------------------------
module register_file_bank
  import register_file_bank_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     NBITS       = 5,
  parameter logic [WORD_LENGTH-1:0] SP_INIT     = SP_INIT_DEFAULT,
  parameter logic [WORD_LENGTH-1:0] GP_INIT     = GP_INIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Reg_Write,
  input  logic [NBITS-1:0]       Write_Register,
  input  logic [WORD_LENGTH-1:0] Write_Data,
  input  logic [NBITS-1:0]       Read_Register_1,
  input  logic [NBITS-1:0]       Read_Register_2,
  output logic [WORD_LENGTH-1:0] Read_Data_1,
  output logic [WORD_LENGTH-1:0] Read_Data_2
);

  logic [WORD_LENGTH-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS*WORD_LENGTH-1:0] w_regs_flat;
  logic                            w_wr_fire;
  logic [NBITS-1:0]                w_rd_addr [2];
  logic [WORD_LENGTH-1:0]          w_rd_data [2];

  // A write commits only outside reset and never to register 0, so register 0
  // keeps its reset value of zero forever.
  assign w_wr_fire = Reg_Write && !reset && (Write_Register != NBITS'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_GP] <= GP_INIT;
      r_regs[REG_SP] <= SP_INIT;
    end else if (w_wr_fire) begin
      r_regs[Write_Register] <= Write_Data;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flatten
    assign w_regs_flat[gi*WORD_LENGTH +: WORD_LENGTH] = r_regs[gi];
  end

  assign w_rd_addr[0] = Read_Register_1;
  assign w_rd_addr[1] = Read_Register_2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
    register_file_read_port #(
      .WORD_LENGTH (WORD_LENGTH),
      .NBITS       (NBITS)
    ) u_read_port (
      .i_regs_flat (w_regs_flat),
      .i_addr      (w_rd_addr[gi]),
      .i_wr_fire   (w_wr_fire),
      .i_wr_addr   (Write_Register),
      .i_wr_data   (Write_Data),
      .o_data      (w_rd_data[gi])
    );
  end

  assign Read_Data_1 = w_rd_data[0];
  assign Read_Data_2 = w_rd_data[1];

endmodule : register_file_bank

// File: tb/tb_register_file_bank.sv
// ---------------------------------------------------------------------------
// tb_register_file_bank
// Self-checking bench for register_file_bank: a directed vector table, an
// all-register sweep, and a randomized run checked against an array model.
// Expectations follow REGFILE_WRITE_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_register_file_bank;

  localparam logic [31:0] SP_V = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_V = 32'h1000_8000;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int vectors     = 0;
  int miscompares = 0;

  register_file_bank dut (
    .clk             (clk),
    .reset           (reset),
    .Reg_Write       (reg_write),
    .Write_Register  (write_register),
    .Write_Data      (write_data),
    .Read_Register_1 (read_register_1),
    .Read_Register_2 (read_register_2),
    .Read_Data_1     (read_data_1),
    .Read_Data_2     (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [13];

  // Drive one cycle of inputs just after the falling edge, then settle so
  // the combinational reads can be sampled well before the next rising edge.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1,
                       input logic [4:0] ra2);
    @(negedge clk);
    reset           = rst;
    reg_write       = we;
    write_register  = wa;
    write_data      = wd;
    read_register_1 = ra1;
    read_register_2 = ra2;
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] model [32];

  initial begin
    // Directed table: expectations are what the read ports show during the
    // row's cycle, before the rising edge that commits the row's write.
    tbl[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd28, 32'h0, GP_V};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd29, 5'd5,  SP_V,  32'h0};
    tbl[2]  = '{1'b0, 1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd9,
                BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  5'd9,  32'hDEAD_BEEF, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 5'd10, 32'h1,         5'd10, 5'd10,
                BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 5'd10, 32'h2,         5'd10, 5'd10,
                BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd10, 5'd10, 32'h2, 32'h2};
    // Reset with a simultaneous write to $sp: no forwarding, write dropped.
    tbl[9]  = '{1'b1, 1'b1, 5'd29, 32'h1234,      5'd29, 5'd8,  SP_V, 32'hDEAD_BEEF};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd29, 5'd8,  SP_V, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 5'd29, 32'h5,         5'd29, 5'd1,  BYP ? 32'h5 : SP_V, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd29, 5'd10, 32'h5, 32'h0};

    reset = 1'b1; reg_write = 1'b0; write_register = '0; write_data = '0;
    read_register_1 = '0; read_register_2 = '0;

    // Initial reset cycle (storage is undefined before it).
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2);
      $display("row %0d: rst=%0d we=%0d wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
               i, tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd,
               tbl[i].ra1, read_data_1, tbl[i].ra2, read_data_2);
      check($sformatf("table%0d_rd1", i), read_data_1, tbl[i].e1);
      check($sformatf("table%0d_rd2", i), read_data_2, tbl[i].e2);
    end

    // Sweep: write every register, then read all of them through both ports.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1;
      logic [31:0] e2;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      e1 = 32'(i) * 32'h0101_0101;
      e2 = 32'(31 - i) * 32'h0101_0101;
      $display("sweep %0d: rd1=%h rd2(reg %0d)=%h", i, read_data_1, 31 - i, read_data_2);
      check($sformatf("sweep_rd1_r%0d", i), read_data_1, e1);
      check($sformatf("sweep_rd2_r%0d", 31 - i), read_data_2, e2);
    end

    // Randomized run against an array model of the architectural registers.
    for (int n = 0; n < 400; n++) begin
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra [2];
      logic [31:0] rd [2];
      logic [31:0] exp_v;
      rst   = (n == 0) || ($urandom_range(0, 15) == 0);
      we    = $urandom_range(0, 1) == 1;
      wa    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra[0] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra[1] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(rst, we, wa, wd, ra[0], ra[1]);
      rd[0] = read_data_1;
      rd[1] = read_data_2;
      $display("rand %0d: rst=%0d we=%0d wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
               n, rst, we, wa, wd, ra[0], rd[0], ra[1], rd[1]);
      if (n != 0) begin
        for (int p = 0; p < 2; p++) begin
          if (ra[p] == 5'd0)
            exp_v = 32'h0;
          else if (BYP && we && !rst && wa == ra[p])
            exp_v = wd;
          else
            exp_v = model[ra[p]];
          check($sformatf("rand%0d_port%0d", n, p + 1), rd[p], exp_v);
        end
      end
      // Advance the model to the state after this cycle's rising edge.
      if (rst) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        model[28] = GP_V;
        model[29] = SP_V;
      end else if (we && wa != 5'd0) begin
        model[wa] = wd;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file_bank
